mux_gate_sequencer: RTL and testbench

MUX_GATE_SEQUENCER -- requirements
Module: mux_gate_sequencer

---
 rtl/mux_gate_seq_pkg.sv | 93 +++++++++
 rtl/mux2x1.sv | 11 +
 rtl/mux_gate_sequencer.sv | 107 ++++++++++
 tb/tb_mux_gate_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_gate_seq_pkg.sv
// Shared types, microprogram table and helpers for the mux-based gate sequencer.
// Every gate is built from repeated passes through a single 2:1 mux.
package mux_gate_seq_pkg;

   typedef enum logic [1:0] {
      OP_INV = 2'd0,
      OP_AND = 2'd1,
      OP_OR  = 2'd2,
      OP_XOR = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_0  = 3'd0,
      SRC_1  = 3'd1,
      SRC_A  = 3'd2,
      SRC_B  = 3'd3,
      SRC_T0 = 3'd4,
      SRC_T1 = 3'd5
   } src_t;

   typedef enum logic [1:0] {
      DST_T0 = 2'd0,
      DST_T1 = 2'd1,
      DST_Y  = 2'd2
   } dst_t;

   typedef struct packed {
      src_t d0;
      src_t d1;
      src_t sel;
      dst_t dst;
   } uinstr_t;

   localparam int          MAX_STEPS = 5;
   localparam logic [2:0]  STEPS_INV = 3'd1;
   localparam logic [2:0]  STEPS_AND = 3'd1;
   localparam logic [2:0]  STEPS_OR  = 3'd1;
   localparam logic [2:0]  STEPS_XOR = 3'd5;

   // Filler for unused table slots; never reached because the step counter stops early.
   localparam uinstr_t NOP = '{d0: SRC_0, d1: SRC_0, sel: SRC_0, dst: DST_Y};

   // XOR = (A & ~B) | (~A & B), assembled in the temporaries before the final OR step.
   localparam uinstr_t [0:3][0:MAX_STEPS-1] UPROG = '{
      '{ '{SRC_1,  SRC_0, SRC_A,  DST_Y},  NOP, NOP, NOP, NOP },
      '{ '{SRC_0,  SRC_A, SRC_B,  DST_Y},  NOP, NOP, NOP, NOP },
      '{ '{SRC_A,  SRC_1, SRC_B,  DST_Y},  NOP, NOP, NOP, NOP },
      '{ '{SRC_1,  SRC_0, SRC_A,  DST_T0},
         '{SRC_1,  SRC_0, SRC_B,  DST_T1},
         '{SRC_0,  SRC_A, SRC_T1, DST_T1},
         '{SRC_0,  SRC_B, SRC_T0, DST_T0},
         '{SRC_T0, SRC_1, SRC_T1, DST_Y} }
   };

   function automatic logic [2:0] step_count(input op_t op);
      case (op)
         OP_INV:  step_count = STEPS_INV;
         OP_AND:  step_count = STEPS_AND;
         OP_OR:   step_count = STEPS_OR;
         default: step_count = STEPS_XOR;
      endcase
   endfunction

   function automatic logic src_value(input src_t s, input logic a, input logic b,
                                      input logic t0, input logic t1);
      case (s)
         SRC_0:   src_value = 1'b0;
         SRC_1:   src_value = 1'b1;
         SRC_A:   src_value = a;
         SRC_B:   src_value = b;
         SRC_T0:  src_value = t0;
         SRC_T1:  src_value = t1;
         default: src_value = 1'b0;
      endcase
   endfunction

   // Reference result using native operators, independent of the mux datapath.
   function automatic logic expected_result(input op_t op, input logic a, input logic b);
      case (op)
         OP_INV:  expected_result = ~a;
         OP_AND:  expected_result = a & b;
         OP_OR:   expected_result = a | b;
         default: expected_result = a ^ b;
      endcase
   endfunction

endpackage

// File: rtl/mux2x1.sv
// The single shared 2:1 mux through which all gate evaluation passes.
module mux2x1 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Accepts one gate command at a time, runs its microprogram through one shared mux,
// returns the result with a valid/ready handshake and self-checks it against a native model.
module mux_gate_sequencer
   import mux_gate_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_vld,
   output logic       in_rdy,
   input  logic [1:0] in_op,
   input  logic       in_a,
   input  logic       in_b,
   output logic       out_vld,
   input  logic       out_rdy,
   output logic [1:0] out_op,
   output logic       out_y,
   output logic       fail
);

   state_t     state;
   state_t     state_nxt;
   op_t        op_q;
   logic       a_q;
   logic       b_q;
   logic       t0;
   logic       t1;
   logic [2:0] step;
   logic       exp_y;
   uinstr_t    uinstr;
   logic       mux_d0;
   logic       mux_d1;
   logic       mux_sel;
   logic       mux_y;
   logic       accept;
   logic       consume;
   logic       last_step;

   assign in_rdy    = (state == IDLE) && !rst;
   assign out_vld   = (state == DONE);
   assign accept    = in_vld && in_rdy;
   assign consume   = out_vld && out_rdy;
   assign last_step = (step == (step_count(op_q) - 3'd1));

   always_comb begin
      uinstr  = UPROG[op_q][step];
      mux_d0  = src_value(uinstr.d0,  a_q, b_q, t0, t1);
      mux_d1  = src_value(uinstr.d1,  a_q, b_q, t0, t1);
      mux_sel = src_value(uinstr.sel, a_q, b_q, t0, t1);
   end

   mux2x1 u_mux (
      .d0  (mux_d0),
      .d1  (mux_d1),
      .sel (mux_sel),
      .y   (mux_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = EXEC;
         EXEC:    if (last_step) state_nxt = DONE;
         DONE:    if (out_rdy)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, microstep execution and the sticky self-check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= OP_INV;
         a_q    <= 1'b0;
         b_q    <= 1'b0;
         t0     <= 1'b0;
         t1     <= 1'b0;
         step   <= 3'd0;
         exp_y  <= 1'b0;
         out_y  <= 1'b0;
         out_op <= 2'd0;
         fail   <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= op_t'(in_op);
            a_q   <= in_a;
            b_q   <= in_b;
            step  <= 3'd0;
            exp_y <= expected_result(op_t'(in_op), in_a, in_b);
         end
         if (state == EXEC) begin
            step <= step + 3'd1;
            case (uinstr.dst)
               DST_T0:  t0    <= mux_y;
               DST_T1:  t1    <= mux_y;
               default: out_y <= mux_y;
            endcase
            if (last_step) out_op <= op_q;
         end
         if (consume && (out_y != exp_y)) fail <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Directed self-checking bench for mux_gate_sequencer.
module tb_mux_gate_sequencer;

   logic       clk;
   logic       rst;
   logic       in_vld;
   logic       in_rdy;
   logic [1:0] in_op;
   logic       in_a;
   logic       in_b;
   logic       out_vld;
   logic       out_rdy;
   logic [1:0] out_op;
   logic       out_y;
   logic       fail;

   int compared;
   int mismatched;

   mux_gate_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_op   (in_op),
      .in_a    (in_a),
      .in_b    (in_b),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_op  (out_op),
      .out_y   (out_y),
      .fail    (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_y(input logic [1:0] op, input logic a, input logic b);
      case (op)
         2'd0:    ref_y = ~a;
         2'd1:    ref_y = a & b;
         2'd2:    ref_y = a | b;
         default: ref_y = a ^ b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op);
      ref_lat = (op == 2'd3) ? 5 : 1;
   endfunction

   // Issues one command with out_rdy held high; reports cycles from accept to out_vld.
   task automatic run_cmd(input logic [1:0] op, input logic a, input logic b,
                          output int lat, output logic y, output logic [1:0] yop);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_rdy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      in_vld  = 1'b1;
      in_op   = op;
      in_a    = a;
      in_b    = b;
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      lat = 0;
      while (!out_vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      y   = out_y;
      yop = out_op;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst     = 1'b1;
      in_vld  = 1'b0;
      in_op   = 2'd0;
      in_a    = 1'b0;
      in_b    = 1'b0;
      out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (in_rdy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_in_rdy: got %b expected 1", in_rdy);
      end
      compared++;
      if ({out_vld, out_y, out_op, fail} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got vld=%b y=%b op=%0d fail=%b expected all 0",
                  out_vld, out_y, out_op, fail);
      end
   endtask

   task automatic test_inv_basic;
      int lat;
      logic y;
      logic [1:0] yop;
      run_cmd(2'd0, 1'b0, 1'b0, lat, y, yop);
      compared++;
      if (lat !== 1) begin
         mismatched++;
         $display("[TB] FAIL inv_latency: got %0d expected 1", lat);
      end
      compared++;
      if (y !== 1'b1 || yop !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL inv_result: got y=%b op=%0d expected y=1 op=0", y, yop);
      end
      compared++;
      if (fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL inv_fail_flag: got %b expected 0", fail);
      end
   endtask

   task automatic test_truth_table;
      int lat;
      logic y;
      logic [1:0] yop;
      for (int op = 0; op < 4; op++) begin
         for (int ab = 0; ab < 4; ab++) begin
            logic a;
            logic b;
            a = ab[1];
            b = ab[0];
            run_cmd(op[1:0], a, b, lat, y, yop);
            compared++;
            if (y !== ref_y(op[1:0], a, b)) begin
               mismatched++;
               $display("[TB] FAIL tt_y op=%0d a=%b b=%b: got %b expected %b",
                        op, a, b, y, ref_y(op[1:0], a, b));
            end
            compared++;
            if (lat !== ref_lat(op[1:0]) || yop !== op[1:0]) begin
               mismatched++;
               $display("[TB] FAIL tt_lat_op op=%0d a=%b b=%b: got lat=%0d op=%0d expected lat=%0d op=%0d",
                        op, a, b, lat, yop, ref_lat(op[1:0]), op);
            end
         end
      end
      compared++;
      if (fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL tt_fail_flag: got %b expected 0", fail);
      end
   endtask

   task automatic test_stall;
      int guard;
      @(negedge clk);
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      in_op   = 2'd3;
      in_a    = 1'b1;
      in_b    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // Keep a conflicting command on the inputs; it must be ignored.
      in_op = 2'd1;
      in_a  = 1'b0;
      in_b  = 1'b0;
      guard = 0;
      while (!out_vld && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 10; i++) begin
         compared++;
         if (out_vld !== 1'b1 || out_y !== 1'b1 || out_op !== 2'd3 || in_rdy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_hold cycle %0d: got vld=%b y=%b op=%0d rdy=%b expected vld=1 y=1 op=3 rdy=0",
                     i, out_vld, out_y, out_op, in_rdy);
         end
         @(negedge clk);
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      compared++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1 || fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL stall_release: got vld=%b rdy=%b fail=%b expected vld=0 rdy=1 fail=0",
                  out_vld, in_rdy, fail);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] ops [4];
      logic       as  [4];
      logic       bs  [4];
      int         acc_cyc [4];
      int         k;
      int         r;
      int         cyc;
      ops = '{2'd1, 2'd3, 2'd2, 2'd0};
      as  = '{1'b1, 1'b1, 1'b0, 1'b1};
      bs  = '{1'b1, 1'b1, 1'b0, 1'b0};
      k   = 0;
      r   = 0;
      cyc = 0;
      out_rdy = 1'b1;
      while (r < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (out_vld) begin
            compared++;
            if (out_y !== ref_y(ops[r], as[r], bs[r]) || out_op !== ops[r]) begin
               mismatched++;
               $display("[TB] FAIL b2b_result %0d: got y=%b op=%0d expected y=%b op=%0d",
                        r, out_y, out_op, ref_y(ops[r], as[r], bs[r]), ops[r]);
            end
            r++;
         end
         if (k < 4) begin
            in_vld = 1'b1;
            in_op  = ops[k];
            in_a   = as[k];
            in_b   = bs[k];
            if (in_rdy) begin
               acc_cyc[k] = cyc;
               k++;
            end
         end else begin
            in_vld = 1'b0;
         end
      end
      in_vld = 1'b0;
      compared++;
      if (r !== 4 || k !== 4) begin
         mismatched++;
         $display("[TB] FAIL b2b_count: got accepts=%0d results=%0d expected 4 and 4", k, r);
      end
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (i + 1 < k && acc_cyc[i+1] - acc_cyc[i] !== ref_lat(ops[i]) + 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_spacing %0d: got %0d expected %0d",
                     i, acc_cyc[i+1] - acc_cyc[i], ref_lat(ops[i]) + 2);
         end else if (i + 1 >= k) begin
            mismatched++;
            $display("[TB] FAIL b2b_spacing %0d: got missing accept expected %0d", i, ref_lat(ops[i]) + 2);
         end
      end
   endtask

   task automatic test_reset_mid_exec;
      int lat;
      logic y;
      logic [1:0] yop;
      @(negedge clk);
      out_rdy = 1'b1;
      in_vld  = 1'b1;
      in_op   = 2'd3;
      in_a    = 1'b1;
      in_b    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (2) @(negedge clk);
      // Now at step s2 of the XOR program.
      rst = 1'b1;
      #1;
      compared++;
      if (out_vld !== 1'b0 || out_y !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrst_async: got vld=%b y=%b expected 0 0", out_vld, out_y);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         compared++;
         if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midrst_idle cycle %0d: got vld=%b rdy=%b expected vld=0 rdy=1",
                     i, out_vld, in_rdy);
         end
      end
      run_cmd(2'd1, 1'b1, 1'b1, lat, y, yop);
      compared++;
      if (y !== 1'b1 || lat !== 1 || yop !== 2'd1) begin
         mismatched++;
         $display("[TB] FAIL midrst_next_and: got y=%b lat=%0d op=%0d expected y=1 lat=1 op=1",
                  y, lat, yop);
      end
   endtask

   task automatic test_fault_inject;
      int lat;
      logic y;
      logic [1:0] yop;
      // INV of 0 should give 1; pinning the mux low inverts the result.
      force dut.mux_y = 1'b0;
      run_cmd(2'd0, 1'b0, 1'b0, lat, y, yop);
      release dut.mux_y;
      compared++;
      if (y !== 1'b0 || fail !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL fault_detect: got y=%b fail=%b expected y=0 fail=1", y, fail);
      end
      run_cmd(2'd2, 1'b1, 1'b0, lat, y, yop);
      compared++;
      if (y !== 1'b1 || fail !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL fault_sticky: got y=%b fail=%b expected y=1 fail=1", y, fail);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (fail !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL fault_cleared: got %b expected 0", fail);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_inv_basic();
      test_truth_table();
      test_stall();
      test_back_to_back();
      test_reset_mid_exec();
      test_fault_inject();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
